// File: rtl/execute_stage.sv
// Execute slice: D/E register, ALU with B-source mux, E/M register.
// Define EXEC_FLUSH_EN to add the flushE bubble input on the D/E register.
module execute_stage #(
  parameter int WIDTH = 32,
  parameter int REGW  = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
`ifdef EXEC_FLUSH_EN
  input  logic             flushE,
`endif
  input  logic [WIDTH-1:0] rd1D,
  input  logic [WIDTH-1:0] store_dataD,
  input  logic [REGW-1:0]  write_regD,
  input  logic [WIDTH-1:0] sign_immD,
  input  logic             alu_srcE,
  input  logic [2:0]       alu_controlE,
  output logic [WIDTH-1:0] src_aE,
  output logic [WIDTH-1:0] rd2E,
  output logic [WIDTH-1:0] write_dataE,
  output logic [REGW-1:0]  write_regE,
  output logic [WIDTH-1:0] sign_immE,
  output logic [WIDTH-1:0] src_bE,
  output logic [WIDTH-1:0] alu_resultE,
  output logic             zeroE,
  output logic [WIDTH-1:0] alu_outM,
  output logic [WIDTH-1:0] write_dataM,
  output logic [REGW-1:0]  write_regM
);

  logic [WIDTH-1:0] src_a_q, src_a_d;
  logic [WIDTH-1:0] rd2_q, rd2_d;
  logic [REGW-1:0]  wreg_e_q, wreg_e_d;
  logic [WIDTH-1:0] imm_q, imm_d;
  logic [WIDTH-1:0] alu_out_q;
  logic [WIDTH-1:0] wdata_m_q;
  logic [REGW-1:0]  wreg_m_q;
  logic [WIDTH-1:0] res;
  logic [4:0]       shamt;
  logic             slt;

  // D/E next state; a flush inserts a bubble targeting x0
  always_comb begin
    src_a_d  = rd1D;
    rd2_d    = store_dataD;
    wreg_e_d = write_regD;
    imm_d    = sign_immD;
`ifdef EXEC_FLUSH_EN
    if (flushE) begin
      src_a_d  = '0;
      rd2_d    = '0;
      wreg_e_d = '0;
      imm_d    = '0;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      src_a_q   <= '0;
      rd2_q     <= '0;
      wreg_e_q  <= '0;
      imm_q     <= '0;
      alu_out_q <= '0;
      wdata_m_q <= '0;
      wreg_m_q  <= '0;
    end else if (en) begin
      src_a_q   <= src_a_d;
      rd2_q     <= rd2_d;
      wreg_e_q  <= wreg_e_d;
      imm_q     <= imm_d;
      alu_out_q <= res;
      wdata_m_q <= rd2_q;
      wreg_m_q  <= wreg_e_q;
    end
  end

  assign src_bE = alu_srcE ? imm_q : rd2_q;
  assign shamt  = src_bE[4:0];
  assign slt    = $signed(src_a_q) < $signed(src_bE);

  always_comb begin
    res = '0;
    unique case (alu_controlE)
      3'b000: res = src_a_q + src_bE;
      3'b001: res = src_a_q - src_bE;
      3'b010: res = src_a_q & src_bE;
      3'b011: res = src_a_q | src_bE;
      3'b100: res = src_a_q ^ src_bE;
      3'b101: res = {{(WIDTH-1){1'b0}}, slt};
      3'b110: res = src_a_q << shamt;
      3'b111: res = src_a_q >> shamt;
      default: res = '0;
    endcase
  end

  assign src_aE      = src_a_q;
  assign rd2E        = rd2_q;
  assign write_dataE = rd2_q;
  assign write_regE  = wreg_e_q;
  assign sign_immE   = imm_q;
  assign alu_resultE = res;
  assign zeroE       = (res == '0);
  assign alu_outM    = alu_out_q;
  assign write_dataM = wdata_m_q;
  assign write_regM  = wreg_m_q;

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage with an M-stage scoreboard.
// Flush checks are built only when EXEC_FLUSH_EN is defined.
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic        flushE;
  logic [31:0] rd1D, store_dataD, sign_immD;
  logic [4:0]  write_regD;
  logic        alu_srcE;
  logic [2:0]  alu_controlE;
  logic [31:0] src_aE, rd2E, write_dataE, sign_immE;
  logic [31:0] src_bE, alu_resultE, alu_outM, write_dataM;
  logic [4:0]  write_regE, write_regM;
  logic        zeroE;

  execute_stage dut (
    .clk          (clk),
    .reset        (reset),
    .en           (en),
`ifdef EXEC_FLUSH_EN
    .flushE       (flushE),
`endif
    .rd1D         (rd1D),
    .store_dataD  (store_dataD),
    .write_regD   (write_regD),
    .sign_immD    (sign_immD),
    .alu_srcE     (alu_srcE),
    .alu_controlE (alu_controlE),
    .src_aE       (src_aE),
    .rd2E         (rd2E),
    .write_dataE  (write_dataE),
    .write_regE   (write_regE),
    .sign_immE    (sign_immE),
    .src_bE       (src_bE),
    .alu_resultE  (alu_resultE),
    .zeroE        (zeroE),
    .alu_outM     (alu_outM),
    .write_dataM  (write_dataM),
    .write_regM   (write_regM)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] out;
    logic [31:0] wd;
    logic [4:0]  wr;
  } m_t;

  m_t          sb[$];
  m_t          mM;
  logic [31:0] mA, mRd2, mImm;
  logic [4:0]  mWr;
  int          n_cmp = 0;
  int          n_bad = 0;

  function automatic logic [31:0] alu_model(logic [2:0] op,
                                            logic [31:0] a,
                                            logic [31:0] b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd6: return a << b[4:0];
      default: return a >> b[4:0];
    endcase
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    mA = '0; mRd2 = '0; mImm = '0; mWr = '0;
    mM = '{out: '0, wd: '0, wr: '0};
  endtask

  task automatic chk_e();
    chk("src_aE", src_aE, mA);
    chk("rd2E", rd2E, mRd2);
    chk("write_dataE", write_dataE, mRd2);
    chk("write_regE", {27'd0, write_regE}, {27'd0, mWr});
    chk("sign_immE", sign_immE, mImm);
  endtask

  // one clock edge: predict, push, wait, pop and compare
  task automatic tick();
    m_t exp;
    if (reset && en) begin
      mM.out = alu_model(alu_controlE, mA, alu_srcE ? mImm : mRd2);
      mM.wd  = mRd2;
      mM.wr  = mWr;
      if (flushE) begin
        mA = '0; mRd2 = '0; mWr = '0; mImm = '0;
      end else begin
        mA = rd1D; mRd2 = store_dataD; mWr = write_regD; mImm = sign_immD;
      end
    end
    sb.push_back(mM);
    @(posedge clk);
    #1;
    exp = sb.pop_front();
    chk("alu_outM", alu_outM, exp.out);
    chk("write_dataM", write_dataM, exp.wd);
    chk("write_regM", {27'd0, write_regM}, {27'd0, exp.wr});
    chk_e();
  endtask

  task automatic drive_d(logic [31:0] a, logic [31:0] sd,
                         logic [4:0] wr, logic [31:0] imm);
    rd1D = a; store_dataD = sd; write_regD = wr; sign_immD = imm;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    m_t pre;
    model_clear();
    flushE = 1'b0;
    reset = 1'b0;
    en = 1'b1;
    alu_srcE = 1'b0;
    alu_controlE = 3'($urandom_range(0, 7));
    for (int i = 0; i < 3; i++) begin
      drive_d($urandom, $urandom, 5'($urandom), $urandom);
      @(posedge clk);
      #1;
    end
    chk_e();
    chk("rst alu_outM", alu_outM, 32'd0);
    chk("rst write_dataM", write_dataM, 32'd0);
    chk("rst write_regM", {27'd0, write_regM}, 32'd0);
    chk("rst src_bE", src_bE, 32'd0);
    chk("rst alu_resultE", alu_resultE, 32'd0);
    chk("rst zeroE", {31'd0, zeroE}, 32'd1);

    // release reset between edges, then ADD through the pipe
    #2 reset = 1'b1;
    alu_controlE = 3'b000;
    alu_srcE = 1'b0;
    drive_d(32'd5, 32'd7, 5'd3, 32'd0);
    tick();
    chk("add E", alu_resultE, 32'd12);
    tick();
    chk("add M out", alu_outM, 32'd12);
    chk("add M wr", {27'd0, write_regM}, 32'd3);
    chk("add M wd", write_dataM, 32'd7);

    // immediate path
    drive_d(32'd100, 32'd1, 5'd4, 32'hFFFF_FFFC);
    alu_srcE = 1'b1;
    tick();
    chk("imm src_bE", src_bE, 32'hFFFF_FFFC);
    chk("imm add", alu_resultE, 32'd96);
    alu_controlE = 3'b001;
    #1 chk("imm sub", alu_resultE, 32'd104);

    // ops sweep with A=0x80000000, B=1
    alu_srcE = 1'b0;
    drive_d(32'h8000_0000, 32'd1, 5'd5, 32'hFFFF_FFE1);
    tick();
    alu_controlE = 3'b101;
    #1 chk("slt", alu_resultE, 32'd1);
    alu_controlE = 3'b111;
    #1 chk("srl", alu_resultE, 32'h4000_0000);
    alu_controlE = 3'b110;
    #1 chk("sll", alu_resultE, 32'd0);
    chk("sll zeroE", {31'd0, zeroE}, 32'd1);
    alu_controlE = 3'b100;
    #1 chk("xor", alu_resultE, 32'h8000_0001);
    alu_controlE = 3'b010;
    #1 chk("and", alu_resultE, 32'd0);
    alu_controlE = 3'b011;
    #1 chk("or", alu_resultE, 32'h8000_0001);
    chk("or zeroE", {31'd0, zeroE}, 32'd0);
    // shift amount uses only B[4:0]: imm 0x...E1 -> shift by 1
    alu_srcE = 1'b1;
    alu_controlE = 3'b111;
    #1 chk("srl b40", alu_resultE, 32'h4000_0000);
    alu_srcE = 1'b0;
    drive_d(32'd3, 32'd3, 5'd6, 32'd0);
    tick();
    alu_controlE = 3'b001;
    #1 chk("sub zero", alu_resultE, 32'd0);
    chk("sub zeroE", {31'd0, zeroE}, 32'd1);

    // stall: load, then hold 3 edges with changing inputs
    alu_controlE = 3'b000;
    drive_d(32'd10, 32'd20, 5'd9, 32'd0);
    tick();
    tick();
    chk("pre-stall M", alu_outM, 32'd30);
    pre = mM;
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_d($urandom, $urandom, 5'($urandom), $urandom);
      tick();
    end
    chk("stall M out", alu_outM, pre.out);
    chk("stall E a", src_aE, 32'd10);
    en = 1'b1;
    drive_d(32'h1234_5678, 32'h0000_0011, 5'd17, 32'd0);
    tick();
    chk("resume E a", src_aE, 32'h1234_5678);
    chk("resume E wr", {27'd0, write_regE}, 32'd17);
    chk("resume M", alu_outM, 32'd30);
    tick();
    chk("resume M2", alu_outM, 32'h1234_5689);

`ifdef EXEC_FLUSH_EN
    drive_d(32'd40, 32'd2, 5'd12, 32'd0);
    tick();
    drive_d(32'd77, 32'd88, 5'd13, 32'd0);
    flushE = 1'b1;
    tick();
    chk("flush wr", {27'd0, write_regE}, 32'd0);
    chk("flush a", src_aE, 32'd0);
    chk("flush M", alu_outM, 32'd42);
    flushE = 1'b0;
`endif

    // async reset between edges
    drive_d(32'd50, 32'd60, 5'd21, 32'd0);
    tick();
    #2 reset = 1'b0;
    #1;
    model_clear();
    chk("arst alu_resultE", alu_resultE, 32'd0);
    chk("arst alu_outM", alu_outM, 32'd0);
    chk("arst write_regM", {27'd0, write_regM}, 32'd0);
    chk("arst src_aE", src_aE, 32'd0);
    chk("arst zeroE", {31'd0, zeroE}, 32'd1);
    #2 reset = 1'b1;
    drive_d(32'd1, 32'd2, 5'd1, 32'd0);
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
